// File: rtl/autoc_lag_accum_pkg.sv
// Shared definitions for the lagged complex autocorrelator: FSM encoding,
// sample packing positions and result-width derivation.
package autoc_lag_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_ACCUM = 2'd2
  } state_e;

  // Samples are packed {I, Q}: Q in the low half, I in the high half.
  localparam int SAMPLE_Q_LSB = 0;

  function automatic int sample_i_lsb(input int width);
    return width;
  endfunction

  // Full growth: product 2W, re/im sum +1, window of 2^acc_log2 products.
  function automatic int calc_out_w(input int width, input int acc_log2);
    return 2 * width + 1 + acc_log2;
  endfunction

endpackage

// File: rtl/autoc_ring_delay.sv
// D-entry sample ring: each strobed sample is written and, in the same edge,
// the sample from L strobes earlier is read out registered (L = 0 bypasses).
module autoc_ring_delay
  import autoc_lag_accum_pkg::*;
#(
  parameter int SAMPLE_W = 32,
  parameter int LAG_LOG2 = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_en,
  input  logic [SAMPLE_W-1:0] i_wr_data,
  input  logic [LAG_LOG2-1:0] i_lag,
  output logic [SAMPLE_W-1:0] o_cur,
  output logic [SAMPLE_W-1:0] o_del
);

  localparam int DEPTH = 1 << LAG_LOG2;

  logic [SAMPLE_W-1:0] r_mem [DEPTH];
  logic [LAG_LOG2-1:0] r_wr_ptr;
  logic [LAG_LOG2-1:0] w_rd_addr;
  logic [SAMPLE_W-1:0] r_cur;
  logic [SAMPLE_W-1:0] r_del;

  // Pointer arithmetic wraps naturally modulo DEPTH.
  assign w_rd_addr = r_wr_ptr - i_lag;

  always_ff @(posedge clk) begin
    if (rst) r_wr_ptr <= '0;
    else if (i_wr_en) r_wr_ptr <= r_wr_ptr + LAG_LOG2'(1);
  end

  // Contents are never reset; priming after every enable rise refills them.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
      r_cur           <= i_wr_data;
      r_del           <= (i_lag == '0) ? i_wr_data : r_mem[w_rd_addr];
    end
  end

  assign o_cur = r_cur;
  assign o_del = r_del;

endmodule

// File: rtl/autoc_lag_accum.sv
// Lagged complex autocorrelator: accumulates x[n]*conj(x[n-L]) over windows
// of N strobed samples and emits one full-precision result per window.
//
// state    | meaning
// ST_IDLE  | disabled; counters cleared, waiting for enable rise
// ST_PRIME | filling the delay line with L strobes, nothing accumulated
// ST_ACCUM | every strobe contributes a product; windows back-to-back
module autoc_lag_accum
  import autoc_lag_accum_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LAG_LOG2 = 5,
  parameter int ACC_LOG2 = 10,
  parameter int OUT_W    = calc_out_w(WIDTH, ACC_LOG2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [LAG_LOG2-1:0]  lag,
  input  logic [ACC_LOG2-1:0]  len_m1,
  output logic                 ddc_out_enable,
  input  logic [2*WIDTH-1:0]   ddc_out_sample,
  input  logic                 ddc_out_strobe,
  output logic [OUT_W-1:0]     si,
  output logic [OUT_W-1:0]     sq,
  output logic                 out_stb,
  output logic                 outputting
);

  localparam int PW   = 2 * WIDTH;
  localparam int ILSB = sample_i_lsb(WIDTH);
  localparam int QLSB = SAMPLE_Q_LSB;

  state_e r_state, w_next;
  logic                r_en_d;
  logic [LAG_LOG2-1:0] r_lag, r_prime_cnt;
  logic [ACC_LOG2-1:0] r_len_m1, r_win_cnt;
  logic                w_rise, w_load, w_prod;

  logic [PW-1:0]       w_cur, w_del;
  logic signed [WIDTH-1:0] w_ic, w_qc, w_id, w_qd;
  logic                r_s1_vld, r_s1_last, r_s2_vld, r_s2_last, r_s3_vld, r_s3_last;
  logic signed [PW-1:0]    r_ii, r_qq, r_qi, r_iq;
  logic signed [PW:0]      r_re, r_im;
  logic signed [OUT_W-1:0] r_acc_re, r_acc_im, r_si, r_sq;
  logic signed [OUT_W-1:0] w_sum_re, w_sum_im;
  logic                r_first, r_out_stb, r_outputting;

  assign w_rise = enable & ~r_en_d;
  assign w_load = w_rise & (r_state == ST_IDLE);
  assign w_prod = ddc_out_strobe & enable & (r_state == ST_ACCUM);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_load) w_next = (lag == '0) ? ST_ACCUM : ST_PRIME;
      ST_PRIME: begin
        if (!enable) w_next = ST_IDLE;
        else if (ddc_out_strobe && r_prime_cnt == LAG_LOG2'(1)) w_next = ST_ACCUM;
      end
      ST_ACCUM: if (!enable) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_en_d      <= 1'b0;
      r_lag       <= '0;
      r_len_m1    <= '0;
      r_prime_cnt <= '0;
      r_win_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_en_d  <= enable;
      if (w_load) begin
        r_lag       <= lag;
        r_len_m1    <= len_m1;
        r_prime_cnt <= lag;
        r_win_cnt   <= len_m1;
      end else if (r_state == ST_IDLE) begin
        r_prime_cnt <= '0;
        r_win_cnt   <= '0;
      end else if (r_state == ST_PRIME && ddc_out_strobe) begin
        r_prime_cnt <= r_prime_cnt - LAG_LOG2'(1);
      end else if (w_prod) begin
        r_win_cnt <= (r_win_cnt == '0) ? r_len_m1 : r_win_cnt - ACC_LOG2'(1);
      end
    end
  end

  autoc_ring_delay #(.SAMPLE_W(PW), .LAG_LOG2(LAG_LOG2)) u_ring (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (ddc_out_strobe),
    .i_wr_data (ddc_out_sample),
    .i_lag     (r_lag),
    .o_cur     (w_cur),
    .o_del     (w_del)
  );

  assign w_ic = w_cur[ILSB +: WIDTH];
  assign w_qc = w_cur[QLSB +: WIDTH];
  assign w_id = w_del[ILSB +: WIDTH];
  assign w_qd = w_del[QLSB +: WIDTH];

  // Dropping enable flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_prod;
      r_s2_vld <= r_s1_vld;
      r_s3_vld <= r_s2_vld;
    end
  end

  always_ff @(posedge clk) begin
    r_s1_last <= (r_win_cnt == '0);
    r_s2_last <= r_s1_last;
    r_s3_last <= r_s2_last;
    r_ii      <= PW'(w_ic) * PW'(w_id);
    r_qq      <= PW'(w_qc) * PW'(w_qd);
    r_qi      <= PW'(w_qc) * PW'(w_id);
    r_iq      <= PW'(w_ic) * PW'(w_qd);
    r_re      <= (PW+1)'(r_ii) + (PW+1)'(r_qq);
    r_im      <= (PW+1)'(r_qi) - (PW+1)'(r_iq);
  end

  // First product of a window loads the accumulator instead of adding.
  assign w_sum_re = (r_first ? '0 : r_acc_re) + OUT_W'(r_re);
  assign w_sum_im = (r_first ? '0 : r_acc_im) + OUT_W'(r_im);

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_acc_re     <= '0;
      r_acc_im     <= '0;
      r_first      <= 1'b1;
      r_out_stb    <= 1'b0;
      r_outputting <= 1'b0;
      if (rst) begin
        r_si <= '0;
        r_sq <= '0;
      end
    end else begin
      r_out_stb <= 1'b0;
      if (r_s3_vld) begin
        if (r_s3_last) begin
          r_si         <= w_sum_re;
          r_sq         <= w_sum_im;
          r_out_stb    <= 1'b1;
          r_outputting <= 1'b1;
          r_first      <= 1'b1;
        end else begin
          r_acc_re <= w_sum_re;
          r_acc_im <= w_sum_im;
          r_first  <= 1'b0;
        end
      end
    end
  end

  assign ddc_out_enable = r_en_d;
  assign si             = r_si;
  assign sq             = r_sq;
  assign out_stb        = r_out_stb;
  assign outputting     = r_outputting;

endmodule

// File: tb/tb_autoc_lag_accum.sv
// Scoreboard bench for autoc_lag_accum: directed windows push expected
// results and arrival cycles; a negedge monitor pops them on out_stb.
module tb_autoc_lag_accum;

  localparam int WIDTH    = 16;
  localparam int LAG_LOG2 = 5;
  localparam int ACC_LOG2 = 10;
  localparam int OUT_W    = 43;

  logic                clk = 1'b0;
  logic                rst, enable, ddc_out_enable, ddc_out_strobe, out_stb, outputting;
  logic [LAG_LOG2-1:0] lag;
  logic [ACC_LOG2-1:0] len_m1;
  logic [2*WIDTH-1:0]  ddc_out_sample;
  logic [OUT_W-1:0]    si, sq;

  always #5 clk = ~clk;

  autoc_lag_accum #(.WIDTH(WIDTH), .LAG_LOG2(LAG_LOG2), .ACC_LOG2(ACC_LOG2), .OUT_W(OUT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .lag            (lag),
    .len_m1         (len_m1),
    .ddc_out_enable (ddc_out_enable),
    .ddc_out_sample (ddc_out_sample),
    .ddc_out_strobe (ddc_out_strobe),
    .si             (si),
    .sq             (sq),
    .out_stb        (out_stb),
    .outputting     (outputting)
  );

  typedef struct {
    longint si;
    longint sq;
    int     cyc;
    string  name;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     cyc = 0;
  int     last_strobe_cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  int     rot_i[4] = '{1000, 0, -1000, 0};
  int     rot_q[4] = '{0, 1000, 0, -1000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  always @(negedge clk) begin
    if (out_stb) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out_stb: got pulse at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_si"}, $signed(si), mon_e.si);
        check({mon_e.name, "_sq"}, $signed(sq), mon_e.sq);
        check({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input int i_val, input int q_val);
    ddc_out_sample = {16'(i_val), 16'(q_val)};
    ddc_out_strobe = 1'b1;
    last_strobe_cyc = cyc;
    tick();
    ddc_out_strobe = 1'b0;
  endtask

  // Result of the window whose last strobe was just issued arrives 4 cycles later.
  task automatic push(input string name, input longint e_si, input longint e_sq);
    exp_t e;
    e.si = e_si; e.sq = e_sq; e.cyc = last_strobe_cyc + 4; e.name = name;
    sb.push_back(e);
  endtask

  task automatic start(input int l, input int n_m1);
    lag = LAG_LOG2'(l);
    len_m1 = ACC_LOG2'(n_m1);
    enable = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; lag = '0; len_m1 = '0;
    ddc_out_sample = '0; ddc_out_strobe = 1'b0;
    idle(3);
    check("rst_si", $signed(si), 0);
    check("rst_sq", $signed(sq), 0);
    check("rst_out_stb", out_stb, 0);
    check("rst_outputting", outputting, 0);
    check("rst_ddc_en", ddc_out_enable, 0);
    rst = 1'b0;
    idle(2);

    // L=0, N=4, constant (1000,0): 4 * 1e6 per window.
    start(0, 3);
    for (int k = 0; k < 12; k++) begin
      strobe(1000, 0);
      if (k % 4 == 3) push("A_energy", 4000000, 0);
    end
    idle(6);
    check("A_outputting", outputting, 1);
    check("A_ddc_en", ddc_out_enable, 1);
    enable = 1'b0;
    tick();
    check("A_outputting_off", outputting, 0);
    check("A_ddc_en_off", ddc_out_enable, 0);
    check("A_si_hold", $signed(si), 4000000);
    idle(3);

    // L=1, N=8, rotation by +90 deg per sample: each product is j*1e6.
    start(1, 7);
    for (int k = 0; k <= 16; k++) begin
      strobe(rot_i[k % 4], rot_q[k % 4]);
      if (k >= 1 && k % 8 == 0) push("B_rot", 0, 8000000);
    end
    idle(6);
    enable = 1'b0;
    idle(3);

    // L=3, N=1024, full-scale negative: 1024 * 2^31 = 2^41.
    start(3, 1023);
    for (int k = 0; k < 1027; k++) begin
      strobe(-32768, -32768);
      if (k == 1026) push("C_fullscale", 64'sd2199023255552, 0);
    end
    idle(6);
    enable = 1'b0;
    idle(3);

    // L=5, N=16, every 3rd cycle, x_k=(k,0): sum_{k=6..21} k(k-5) = 2176.
    start(5, 15);
    for (int k = 1; k <= 21; k++) begin
      strobe(k, 0);
      if (k == 21) push("D_gapped", 2176, 0);
      idle(2);
    end
    idle(4);
    enable = 1'b0;
    idle(3);

    // Abort after 10 of 16 products: no result, outputs hold.
    start(0, 15);
    for (int k = 0; k < 10; k++) strobe(7, 0);
    enable = 1'b0;
    tick();
    check("E_outputting", outputting, 0);
    idle(8);
    check("E_si_hold", $signed(si), 2176);
    check("E_sq_hold", $signed(sq), 0);

    // Re-enable with L=2, N=4, x_k=(k,0): windows k=3..6 -> 50, k=7..10 -> 226.
    start(2, 3);
    for (int k = 1; k <= 10; k++) begin
      strobe(k, 0);
      if (k == 6) push("E_reconf_w1", 50, 0);
      if (k == 10) push("E_reconf_w2", 226, 0);
    end
    idle(6);
    check("E_reconf_outputting", outputting, 1);

    // Reset mid-window while still enabled.
    for (int k = 0; k < 3; k++) strobe(50, 0);
    rst = 1'b1;
    enable = 1'b0;
    tick();
    check("F_rst_si", $signed(si), 0);
    check("F_rst_sq", $signed(sq), 0);
    check("F_rst_out_stb", out_stb, 0);
    check("F_rst_outputting", outputting, 0);
    check("F_rst_ddc_en", ddc_out_enable, 0);
    rst = 1'b0;
    idle(8);

    // Restart after reset, L=0, N=8, (100,0): 8 * 1e4.
    start(0, 7);
    for (int k = 0; k < 8; k++) strobe(100, 0);
    push("F_restart", 80000, 0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d results outstanding, expected 0", sb.size());
    end
    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
